// File: rtl/calib_pkg.sv
// Purpose: shared state encoding and bit-count derivations for the calibration sweep.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Used by calibration_sequencer and by anything that sizes id_shower bit-number ports.
package calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_FRAME,
    SETTLE,
    CAPTURE
  } calib_state_t;

  // Number of LED address bits swept for a given LED count.
  function automatic int calc_num_bits(input int num_leds);
    return $clog2(num_leds);
  endfunction

  // Width needed to name one address bit; never narrower than 1.
  function automatic int calc_bit_num_width(input int num_bits);
    return (num_bits <= 1) ? 1 : $clog2(num_bits);
  endfunction

endpackage

// File: rtl/calib_timer.sv
// Purpose: clear/enable saturating up-counter with a terminal-count compare.
// Latency: tc is combinational from the registered count; clear takes effect next cycle.
// Backpressure: none; the counter holds at all-ones instead of wrapping.
// Ports: clk, rst_n, clr (sync clear, wins over en), en (count), tc_val (compare), tc (count==tc_val).
module calib_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/calibration_sequencer.sv
// Purpose: steps id_shower through every LED address bit and requests one capture per bit.
// Latency: LOAD 1 cycle after start/ack; capture_req SETTLE_CYCLES+1 cycles after frame qualifies.
// Backpressure: capture_req is held until capture_ack; abort cancels from any busy state.
// Ports: start/abort (control), frame_valid/shower_bit_num (from id_shower),
//        update_bit_num/bit_num_req (to id_shower), capture_req/capture_ack/capture_bit (capture block),
//        busy/done/timeout_err (status; done and timeout_err are sticky until the next start).
module calibration_sequencer
  import calib_pkg::*;
#(
  parameter  int NUM_LEDS       = 50,
  parameter  int SETTLE_CYCLES  = 1024,
  parameter  int TIMEOUT_CYCLES = 2**20,
  localparam int NUM_BITS       = calc_num_bits(NUM_LEDS),
  localparam int BIT_NUM_WIDTH  = calc_bit_num_width(NUM_BITS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     frame_valid,
  input  logic [BIT_NUM_WIDTH-1:0] shower_bit_num,
  output logic                     update_bit_num,
  output logic [BIT_NUM_WIDTH-1:0] bit_num_req,
  output logic                     capture_req,
  input  logic                     capture_ack,
  output logic [BIT_NUM_WIDTH-1:0] capture_bit,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int TIMER_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);
  localparam logic [TW-1:0]            SETTLE_TC  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]            TIMEOUT_TC = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_NUM_WIDTH-1:0] LAST_BIT   = BIT_NUM_WIDTH'(NUM_BITS - 1);

  calib_state_t             state_q, state_d;
  logic [BIT_NUM_WIDTH-1:0] bit_idx_q, bit_idx_d;
  logic                     done_q, done_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     update_bit_num_q, update_bit_num_d;
  logic [BIT_NUM_WIDTH-1:0] bit_num_req_q, bit_num_req_d;
  logic                     capture_req_q, capture_req_d;
  logic [BIT_NUM_WIDTH-1:0] capture_bit_q, capture_bit_d;
  logic                     busy_q, busy_d;

  logic          timer_clr;
  logic          timer_en;
  logic [TW-1:0] timer_tc_val;
  logic          timer_tc;

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;

    // abort outranks every other event; in IDLE it just suppresses start.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d       = LOAD;
            bit_idx_d     = '0;
            done_d        = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        LOAD: state_d = WAIT_FRAME;
        WAIT_FRAME: begin
          // A valid frame still showing the previous bit must not count.
          if (frame_valid && (shower_bit_num == bit_idx_q)) begin
            state_d = SETTLE;
          end else if (timer_tc) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end
        end
        SETTLE: begin
          if (!frame_valid) begin
            state_d = WAIT_FRAME;
          end else if (timer_tc) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (capture_ack) begin
            if (bit_idx_q == LAST_BIT) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + BIT_NUM_WIDTH'(1);
              state_d   = LOAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Every state change restarts the shared timer so each waiting state counts from 0.
    timer_en     = (state_q == WAIT_FRAME) || (state_q == SETTLE);
    timer_clr    = (state_d != state_q) || !timer_en;
    timer_tc_val = (state_q == SETTLE) ? SETTLE_TC : TIMEOUT_TC;

    // Outputs are registered from the next state so they are glitch-free Moore signals.
    update_bit_num_d = (state_d == LOAD);
    bit_num_req_d    = (state_d == LOAD) ? bit_idx_d : '0;
    capture_req_d    = (state_d == CAPTURE);
    capture_bit_d    = (state_d == CAPTURE) ? bit_idx_d : '0;
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bit_idx_q        <= '0;
      done_q           <= 1'b0;
      timeout_err_q    <= 1'b0;
      update_bit_num_q <= 1'b0;
      bit_num_req_q    <= '0;
      capture_req_q    <= 1'b0;
      capture_bit_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_idx_q        <= bit_idx_d;
      done_q           <= done_d;
      timeout_err_q    <= timeout_err_d;
      update_bit_num_q <= update_bit_num_d;
      bit_num_req_q    <= bit_num_req_d;
      capture_req_q    <= capture_req_d;
      capture_bit_q    <= capture_bit_d;
      busy_q           <= busy_d;
    end
  end

  calib_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc_val (timer_tc_val),
    .tc     (timer_tc)
  );

  assign update_bit_num = update_bit_num_q;
  assign bit_num_req    = bit_num_req_q;
  assign capture_req    = capture_req_q;
  assign capture_bit    = capture_bit_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Purpose: directed self-checking bench for calibration_sequencer with a behavioural id_shower.
// Latency: n/a.
// Backpressure: n/a.
module tb_calibration_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       frame_valid;
  logic [2:0] shower_bit_num;
  logic       update_bit_num;
  logic [2:0] bit_num_req;
  logic       capture_req;
  logic       capture_ack;
  logic [2:0] capture_bit;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cnt  = 0;
  int upd_cnt  = 0;
  logic req_prev = 1'b0;

  // id_shower model: frame valid 10 cycles after an update; bench can kill or fake the bit.
  logic       model_valid;
  logic [2:0] model_bit;
  int         model_cnt;
  logic       fv_kill;
  logic       stale_en;
  logic [2:0] stale_val;

  calibration_sequencer #(
    .NUM_LEDS       (50),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .frame_valid    (frame_valid),
    .shower_bit_num (shower_bit_num),
    .update_bit_num (update_bit_num),
    .bit_num_req    (bit_num_req),
    .capture_req    (capture_req),
    .capture_ack    (capture_ack),
    .capture_bit    (capture_bit),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bit   <= '0;
      model_cnt   <= 0;
      model_valid <= 1'b0;
    end else if (update_bit_num) begin
      model_bit   <= bit_num_req;
      model_cnt   <= 10;
      model_valid <= 1'b0;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_valid <= 1'b1;
    end
  end

  assign frame_valid    = model_valid & ~fv_kill;
  assign shower_bit_num = stale_en ? stale_val : model_bit;

  always @(negedge clk) begin
    if (capture_req && !req_prev) req_cnt++;
    req_prev = capture_req;
    if (update_bit_num) upd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_upd(output int c);
    int t = 0;
    while (!update_bit_num && t < 100) begin @(negedge clk); t++; end
    check("wait_update", {31'b0, update_bit_num}, 1);
    c = cyc;
  endtask

  task automatic wait_fv(output int c);
    int t = 0;
    while (!frame_valid && t < 100) begin @(negedge clk); t++; end
    check("wait_frame_valid", {31'b0, frame_valid}, 1);
    c = cyc;
  endtask

  task automatic wait_req(output int c);
    int t = 0;
    while (!capture_req && t < 200) begin @(negedge clk); t++; end
    check("wait_capture_req", {31'b0, capture_req}, 1);
    c = cyc;
  endtask

  // One bit of a sweep: LOAD, frame, settle, capture, ack two cycles after the request.
  task automatic do_bit(input int b, input logic last);
    int c, q, r;
    wait_upd(c);
    check($sformatf("load_bit%0d", b), {29'b0, bit_num_req}, b);
    @(negedge clk);
    wait_fv(q);
    wait_req(r);
    check($sformatf("req_latency_bit%0d", b), r, q + 5);
    check($sformatf("capture_bit%0d", b), {29'b0, capture_bit}, b);
    @(negedge clk);
    @(negedge clk);
    if (last) begin
      check("busy_before_done", {31'b0, busy}, 1);
      check("done_before_last_ack", {31'b0, done}, 0);
    end
    capture_ack = 1'b1;
    @(negedge clk);
    capture_ack = 1'b0;
    check($sformatf("req_drop_bit%0d", b), {31'b0, capture_req}, 0);
    check($sformatf("next_load_bit%0d", b), {31'b0, update_bit_num}, {31'b0, ~last});
    if (last) begin
      check("done_set", {31'b0, done}, 1);
      check("busy_clear", {31'b0, busy}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, q, r, s, r0, u0, rel;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; capture_ack = 1'b0;
    fv_kill = 1'b0; stale_en = 1'b0; stale_val = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_update",  {31'b0, update_bit_num}, 0);
    check("rst_bit_req", {29'b0, bit_num_req}, 0);
    check("rst_req",     {31'b0, capture_req}, 0);
    check("rst_cap_bit", {29'b0, capture_bit}, 0);
    check("rst_busy",    {31'b0, busy}, 0);
    check("rst_done",    {31'b0, done}, 0);
    check("rst_timeout", {31'b0, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep of 6 bits
    u0 = upd_cnt; r0 = req_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int b = 0; b < 6; b++) do_bit(b, (b == 5));
    check("sweep_load_count", upd_cnt - u0, 6);
    check("sweep_req_count", req_cnt - r0, 6);
    check("sweep_no_timeout", {31'b0, timeout_err}, 0);

    // Settle glitch: one low cycle during SETTLE restarts the stable window
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("glitch_done_cleared", {31'b0, done}, 0);
    wait_upd(c);
    @(negedge clk);
    wait_fv(q);
    @(negedge clk);
    fv_kill = 1'b1;
    @(negedge clk);
    fv_kill = 1'b0;
    check("glitch_no_early_req", {31'b0, capture_req}, 0);
    wait_req(r);
    check("glitch_req_cycle", r, q + 7);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("glitch_abort_busy", {31'b0, busy}, 0);
    check("glitch_abort_req", {31'b0, capture_req}, 0);

    // Timeout: frame never valid
    fv_kill = 1'b1; r0 = req_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("to_load", {31'b0, update_bit_num}, 1);
    s = cyc;
    while (cyc < s + 64) @(negedge clk);
    check("to_busy_last_wait", {31'b0, busy}, 1);
    check("to_err_not_yet", {31'b0, timeout_err}, 0);
    @(negedge clk);
    check("to_busy", {31'b0, busy}, 0);
    check("to_err", {31'b0, timeout_err}, 1);
    check("to_no_req", req_cnt - r0, 0);
    fv_kill = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("to_err_cleared", {31'b0, timeout_err}, 0);

    // Abort together with ack in CAPTURE of bit 3
    for (int b = 0; b < 3; b++) do_bit(b, 1'b0);
    wait_upd(c);
    check("ab_load_bit3", {29'b0, bit_num_req}, 3);
    @(negedge clk);
    wait_fv(q);
    wait_req(r);
    check("ab_capture_bit3", {29'b0, capture_bit}, 3);
    capture_ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    capture_ack = 1'b0; abort = 1'b0;
    check("ab_busy", {31'b0, busy}, 0);
    check("ab_done", {31'b0, done}, 0);
    check("ab_req", {31'b0, capture_req}, 0);
    check("ab_no_load", {31'b0, update_bit_num}, 0);

    // Stale bit number: valid frame of the wrong bit must not qualify
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_upd(c);
    stale_en = 1'b1; stale_val = 3'd3;
    repeat (20) @(negedge clk);
    check("stale_busy", {31'b0, busy}, 1);
    check("stale_no_req", {31'b0, capture_req}, 0);
    stale_en = 1'b0;
    rel = cyc;
    wait_req(r);
    check("stale_release_latency", r, rel + 5);
    check("stale_capture_bit", {29'b0, capture_bit}, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Reset in SETTLE of bit 2
    start = 1'b1; @(negedge clk); start = 1'b0;
    do_bit(0, 1'b0);
    do_bit(1, 1'b0);
    wait_upd(c);
    check("rs_load_bit2", {29'b0, bit_num_req}, 2);
    @(negedge clk);
    wait_fv(q);
    @(negedge clk);
    check("rs_busy_pre", {31'b0, busy}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_busy", {31'b0, busy}, 0);
    check("rs_update", {31'b0, update_bit_num}, 0);
    check("rs_req", {31'b0, capture_req}, 0);
    check("rs_done", {31'b0, done}, 0);
    check("rs_timeout", {31'b0, timeout_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("rs_restart_load", {31'b0, update_bit_num}, 1);
    check("rs_restart_bit0", {29'b0, bit_num_req}, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
